// File: rtl/pa_core_gpr_pkg.sv
// pa_core_gpr_pkg: shared constants for the GPR file (FSM states, register counts, zero word)
package pa_core_gpr_pkg;

   typedef enum logic {
      GPR_ST_CLR,
      GPR_ST_RUN
   } gpr_st_e;

   localparam int GPR_REG_NUM_RV32I = 32;
   localparam int GPR_REG_NUM_RV32E = 16;
   localparam logic [63:0] ZERO_WORD = '0;

endpackage

// File: rtl/pa_core_gpr_if.sv
// pa_core_gpr_if: decode/writeback/issue bundle of the GPR file; master = core pipeline, slave = register file
interface pa_core_gpr_if
   import pa_core_gpr_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int REG_NUM  = GPR_REG_NUM_RV32I,
   parameter int RD_PORTS = 2
);

   localparam int ADDR_W = $clog2(REG_NUM);

   logic [RD_PORTS*ADDR_W-1:0] rd_addr;
   logic [RD_PORTS*DATA_W-1:0] rd_data;
   logic [RD_PORTS-1:0]        rd_pend;
   logic                       wr_vld;
   logic [ADDR_W-1:0]          wr_addr;
   logic [DATA_W-1:0]          wr_data;
   logic                       sb_set_vld;
   logic [ADDR_W-1:0]          sb_set_addr;
   logic                       ready;

   modport master (
      output rd_addr, wr_vld, wr_addr, wr_data, sb_set_vld, sb_set_addr,
      input  rd_data, rd_pend, ready
   );

   modport slave (
      input  rd_addr, wr_vld, wr_addr, wr_data, sb_set_vld, sb_set_addr,
      output rd_data, rd_pend, ready
   );

endinterface

// File: rtl/pa_core_gpr_sb.sv
// pa_core_gpr_sb: per-register pending bits with issue-set, writeback-clear and per-port lookup
module pa_core_gpr_sb
   import pa_core_gpr_pkg::*;
#(
   parameter  int REG_NUM  = GPR_REG_NUM_RV32I,
   parameter  int RD_PORTS = 2,
   localparam int ADDR_W   = $clog2(REG_NUM)
) (
   input  logic                       clk_i,
   input  logic                       rst_n_i,
   input  logic                       en,
   input  logic                       set_vld,
   input  logic [ADDR_W-1:0]          set_addr,
   input  logic                       clr_vld,
   input  logic [ADDR_W-1:0]          clr_addr,
   input  logic [RD_PORTS*ADDR_W-1:0] rd_addr,
   output logic [RD_PORTS-1:0]        rd_pend
);

   logic [REG_NUM-1:0] pend;
   logic [REG_NUM-1:0] set_mask;
   logic [REG_NUM-1:0] clr_mask;

   // one-hot set/clear decode; x0 can never become pending
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (set_vld) set_mask[set_addr] = 1'b1;
      if (clr_vld) clr_mask[clr_addr] = 1'b1;
      set_mask[0] = 1'b0;
   end

   // set is applied after clear so a new producer on the same register wins
   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) pend <= '0;
      else if (en) pend <= (pend & ~clr_mask) | set_mask;

   // a register written this cycle is served by the bypass, so it is not reported pending
   always_comb begin
      rd_pend = '0;
      for (int k = 0; k < RD_PORTS; k++)
         rd_pend[k] = en & pend[rd_addr[k*ADDR_W +: ADDR_W]]
                      & ~(clr_vld & (clr_addr == rd_addr[k*ADDR_W +: ADDR_W]));
   end

endmodule

// File: rtl/pa_core_gpr.sv
// pa_core_gpr: REG_NUM x DATA_W GPR file, x0 = 0, write bypass, post-reset clear; PA_CORE_GPR_SCOREBOARD_EN adds pending scoreboard
module pa_core_gpr
   import pa_core_gpr_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int REG_NUM  = GPR_REG_NUM_RV32I,
   parameter int RD_PORTS = 2
) (
   input logic          clk_i,
   input logic          rst_n_i,
   pa_core_gpr_if.slave bus
);

   localparam int ADDR_W = $clog2(REG_NUM);

   gpr_st_e           st;
   logic [ADDR_W-1:0] clr_idx;
   logic [DATA_W-1:0] mem [REG_NUM];
   logic              run;
   logic              wr_en;
   logic [ADDR_W-1:0] rd_a;

   assign run   = st == GPR_ST_RUN;
   assign wr_en = run & bus.wr_vld & (bus.wr_addr != '0);

   // clear sequencer: zero x1..x(REG_NUM-1) one per cycle, then run until the next reset
   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) begin
         st        <= GPR_ST_CLR;
         clr_idx   <= ADDR_W'(1);
         bus.ready <= 1'b0;
      end else if (st == GPR_ST_CLR) begin
         clr_idx <= clr_idx + ADDR_W'(1);
         if (clr_idx == ADDR_W'(REG_NUM - 1)) begin
            st        <= GPR_ST_RUN;
            bus.ready <= 1'b1;
         end
      end

   // storage has no reset so it can map to LUT-RAM; the sequencer owns the write port while clearing
   always_ff @(posedge clk_i)
      if (!run) mem[clr_idx] <= ZERO_WORD[DATA_W-1:0];
      else if (wr_en) mem[bus.wr_addr] <= bus.wr_data;

   // read ports: zero while clearing or for x0, else bypass a same-cycle write, else storage
   always_comb begin
      bus.rd_data = '0;
      rd_a        = '0;
      for (int k = 0; k < RD_PORTS; k++) begin
         rd_a = bus.rd_addr[k*ADDR_W +: ADDR_W];
         if (run && rd_a != '0)
            bus.rd_data[k*DATA_W +: DATA_W] = (bus.wr_vld && bus.wr_addr == rd_a) ? bus.wr_data : mem[rd_a];
      end
   end

`ifdef PA_CORE_GPR_SCOREBOARD_EN
   pa_core_gpr_sb #(
      .REG_NUM  (REG_NUM),
      .RD_PORTS (RD_PORTS)
   ) u_sb (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .en       (run),
      .set_vld  (bus.sb_set_vld),
      .set_addr (bus.sb_set_addr),
      .clr_vld  (bus.wr_vld),
      .clr_addr (bus.wr_addr),
      .rd_addr  (bus.rd_addr),
      .rd_pend  (bus.rd_pend)
   );
`else
   logic unused_sb;
   assign unused_sb   = ^{bus.sb_set_vld, bus.sb_set_addr};
   assign bus.rd_pend = '0;
`endif

endmodule

// File: tb/tb_pa_core_gpr.sv
// tb_pa_core_gpr: randomized and directed checks of pa_core_gpr (32x2 and 16x3 instances) against a behavioural model
module tb_pa_core_gpr;

`ifdef PA_CORE_GPR_SCOREBOARD_EN
   localparam bit SB = 1'b1;
`else
   localparam bit SB = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   fails = 0;
   bit   m_run = 1'b0;
   logic [31:0] mm [32];
   logic [31:0] mp;

   always #5 clk = ~clk;

   pa_core_gpr_if #(.DATA_W(32), .REG_NUM(32), .RD_PORTS(2)) b32 ();
   pa_core_gpr_if #(.DATA_W(32), .REG_NUM(16), .RD_PORTS(3)) b16 ();

   pa_core_gpr #(.DATA_W(32), .REG_NUM(32), .RD_PORTS(2)) u32 (.clk_i(clk), .rst_n_i(rst_n), .bus(b32));
   pa_core_gpr #(.DATA_W(32), .REG_NUM(16), .RD_PORTS(3)) u16 (.clk_i(clk), .rst_n_i(rst_n), .bus(b16));

   function automatic logic [31:0] exp_data(input logic [4:0] a);
      if (a == 0) return 32'd0;
      if (b32.wr_vld && b32.wr_addr == a) return b32.wr_data;
      return mm[a];
   endfunction

   function automatic logic exp_pend(input logic [4:0] a);
      return SB && mp[a] && !(b32.wr_vld && b32.wr_addr == a);
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 32; i++) mm[i] = 32'd0;
      mp = 32'd0;
   endtask

   task automatic idle();
      b32.wr_vld = 0; b32.wr_addr = 0; b32.wr_data = 0; b32.sb_set_vld = 0; b32.sb_set_addr = 0;
      b16.wr_vld = 0; b16.wr_addr = 0; b16.wr_data = 0; b16.sb_set_vld = 0; b16.sb_set_addr = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      if (m_run) begin
         if (b32.wr_vld && b32.wr_addr != 0) mm[b32.wr_addr] = b32.wr_data;
         if (b32.wr_vld) mp[b32.wr_addr] = 1'b0;
         if (b32.sb_set_vld && b32.sb_set_addr != 0) mp[b32.sb_set_addr] = 1'b1;
      end
      #1;
   endtask

   task automatic test_reset();
      int r32 = 0;
      int r16 = 0;
      rst_n = 0;
      m_run = 0;
      b32.wr_vld = 1; b32.wr_addr = 5'd9; b32.wr_data = $urandom; b32.sb_set_vld = 1; b32.sb_set_addr = 5'd9;
      b32.rd_addr = {5'd9, 5'd9};
      b16.rd_addr = 12'd0;
      #1;
      checks++; if (b32.ready !== 1'b0) begin fails++; $display("FAIL reset_ready32: got %b exp 0", b32.ready); end
      checks++; if (b16.ready !== 1'b0) begin fails++; $display("FAIL reset_ready16: got %b exp 0", b16.ready); end
      checks++; if (b32.rd_data !== 64'd0) begin fails++; $display("FAIL reset_data: got %h exp 0", b32.rd_data); end
      checks++; if (b32.rd_pend !== 2'b00) begin fails++; $display("FAIL reset_pend: got %b exp 0", b32.rd_pend); end
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      for (int i = 1; i <= 40; i++) begin
         if (r32 == 0) begin
            b32.wr_vld = 1'($urandom); b32.wr_addr = 5'($urandom); b32.wr_data = $urandom;
            b32.sb_set_vld = 1'($urandom); b32.sb_set_addr = 5'($urandom);
            b32.rd_addr = {b32.wr_addr, b32.sb_set_addr};
         end else begin
            b32.wr_vld = 0; b32.sb_set_vld = 0;
         end
         if (r16 == 0) begin
            b16.wr_vld = 1'($urandom); b16.wr_addr = 4'($urandom); b16.wr_data = $urandom;
            b16.sb_set_vld = 1'($urandom); b16.sb_set_addr = 4'($urandom);
         end else begin
            b16.wr_vld = 0; b16.sb_set_vld = 0;
         end
         @(posedge clk);
         #1;
         if (r32 == 0 && b32.ready === 1'b1) r32 = i;
         if (r16 == 0 && b16.ready === 1'b1) r16 = i;
         if (r32 == 0) begin
            checks++;
            if (b32.rd_data !== 64'd0 || b32.rd_pend !== 2'b00) begin
               fails++; $display("FAIL clr_quiet cyc%0d: got data %h pend %b exp 0/0", i, b32.rd_data, b32.rd_pend);
            end
         end
      end
      checks++; if (r32 != 31) begin fails++; $display("FAIL clr_len32: got %0d cycles exp 31", r32); end
      checks++; if (r16 != 15) begin fails++; $display("FAIL clr_len16: got %0d cycles exp 15", r16); end
      idle();
      model_clear();
      m_run = 1;
      for (int a = 1; a < 32; a++) begin
         b32.rd_addr = {5'(a), 5'(a)};
         #1;
         checks++; if (b32.rd_data !== 64'd0) begin fails++; $display("FAIL cleared32 x%0d: got %h exp 0", a, b32.rd_data); end
      end
      for (int a = 1; a < 16; a++) begin
         b16.rd_addr = {4'(a), 4'(a), 4'(a)};
         #1;
         checks++; if (b16.rd_data !== 96'd0) begin fails++; $display("FAIL cleared16 x%0d: got %h exp 0", a, b16.rd_data); end
      end
   endtask

   task automatic test_bypass();
      idle();
      b32.wr_vld = 1; b32.wr_addr = 5'd5; b32.wr_data = 32'hDEADBEEF;
      b32.rd_addr = {5'd6, 5'd5};
      #1;
      checks++; if (b32.rd_data[31:0] !== 32'hDEADBEEF) begin fails++; $display("FAIL bypass_x5: got %h exp deadbeef", b32.rd_data[31:0]); end
      checks++; if (b32.rd_data[63:32] !== exp_data(5'd6)) begin fails++; $display("FAIL bypass_x6: got %h exp %h", b32.rd_data[63:32], exp_data(5'd6)); end
      tick();
      idle();
      #1;
      checks++; if (b32.rd_data[31:0] !== 32'hDEADBEEF) begin fails++; $display("FAIL stored_x5: got %h exp deadbeef", b32.rd_data[31:0]); end
   endtask

   task automatic test_x0();
      idle();
      b32.wr_vld = 1; b32.wr_addr = 5'd0; b32.wr_data = 32'h12345678;
      b32.rd_addr = {5'd0, 5'd0};
      #1;
      checks++; if (b32.rd_data !== 64'd0) begin fails++; $display("FAIL x0_bypass: got %h exp 0", b32.rd_data); end
      tick();
      idle();
      #1;
      checks++; if (b32.rd_data !== 64'd0) begin fails++; $display("FAIL x0_next: got %h exp 0", b32.rd_data); end
      tick();
      checks++; if (b32.rd_data !== 64'd0) begin fails++; $display("FAIL x0_later: got %h exp 0", b32.rd_data); end
   endtask

   task automatic test_scoreboard();
      idle();
      b32.rd_addr = {5'd7, 5'd7};
      b32.sb_set_vld = 1; b32.sb_set_addr = 5'd7;
      #1;
      checks++; if (b32.rd_pend !== 2'b00) begin fails++; $display("FAIL sb_before_set: got %b exp 00", b32.rd_pend); end
      tick();
      idle();
      #1;
      checks++; if (b32.rd_pend !== (SB ? 2'b11 : 2'b00)) begin fails++; $display("FAIL sb_set_x7: got %b exp %b", b32.rd_pend, SB ? 2'b11 : 2'b00); end
      b32.wr_vld = 1; b32.wr_addr = 5'd7; b32.wr_data = 32'h55;
      #1;
      checks++; if (b32.rd_pend !== 2'b00) begin fails++; $display("FAIL sb_wb_pend: got %b exp 00", b32.rd_pend); end
      checks++; if (b32.rd_data !== {32'h55, 32'h55}) begin fails++; $display("FAIL sb_wb_data: got %h exp 55/55", b32.rd_data); end
      tick();
      idle();
      #1;
      checks++; if (b32.rd_pend !== 2'b00) begin fails++; $display("FAIL sb_after_wb: got %b exp 00", b32.rd_pend); end
      b32.sb_set_vld = 1; b32.sb_set_addr = 5'd7;
      b32.wr_vld = 1; b32.wr_addr = 5'd7; b32.wr_data = 32'h77;
      #1;
      checks++; if (b32.rd_data !== {32'h77, 32'h77}) begin fails++; $display("FAIL sb_setwr_data: got %h exp 77/77", b32.rd_data); end
      tick();
      idle();
      #1;
      checks++; if (b32.rd_pend !== (SB ? 2'b11 : 2'b00)) begin fails++; $display("FAIL sb_set_wins: got %b exp %b", b32.rd_pend, SB ? 2'b11 : 2'b00); end
      b32.sb_set_vld = 1; b32.sb_set_addr = 5'd0;
      tick();
      idle();
      b32.rd_addr = {5'd0, 5'd0};
      #1;
      checks++; if (b32.rd_pend !== 2'b00) begin fails++; $display("FAIL sb_x0: got %b exp 00", b32.rd_pend); end
   endtask

   task automatic test_random();
      logic [4:0] a0, a1;
      for (int n = 0; n < 400; n++) begin
         b32.wr_vld = 1'($urandom); b32.wr_addr = 5'($urandom); b32.wr_data = $urandom;
         b32.sb_set_vld = 1'($urandom);
         b32.sb_set_addr = ($urandom_range(0, 3) == 0) ? b32.wr_addr : 5'($urandom);
         a0 = ($urandom_range(0, 2) == 0) ? b32.wr_addr : 5'($urandom);
         a1 = ($urandom_range(0, 3) == 0) ? a0 : 5'($urandom);
         b32.rd_addr = {a1, a0};
         #1;
         checks++; if (b32.rd_data[31:0] !== exp_data(a0)) begin fails++; $display("FAIL rand_data0 n%0d x%0d: got %h exp %h", n, a0, b32.rd_data[31:0], exp_data(a0)); end
         checks++; if (b32.rd_data[63:32] !== exp_data(a1)) begin fails++; $display("FAIL rand_data1 n%0d x%0d: got %h exp %h", n, a1, b32.rd_data[63:32], exp_data(a1)); end
         checks++; if (b32.rd_pend !== {exp_pend(a1), exp_pend(a0)}) begin fails++; $display("FAIL rand_pend n%0d: got %b exp %b", n, b32.rd_pend, {exp_pend(a1), exp_pend(a0)}); end
         tick();
      end
      idle();
   endtask

   task automatic test_reset_mid();
      int r;
      idle();
      rst_n = 0;
      m_run = 0;
      #1;
      checks++; if (b32.ready !== 1'b0) begin fails++; $display("FAIL mid_rst_run: got %b exp 0", b32.ready); end
      @(posedge clk);
      #1 rst_n = 1;
      repeat (9) @(posedge clk);
      #2 rst_n = 0;
      #1;
      checks++; if (b32.ready !== 1'b0) begin fails++; $display("FAIL mid_rst_clr: got %b exp 0", b32.ready); end
      @(posedge clk);
      #1 rst_n = 1;
      r = 0;
      for (int i = 1; i <= 60 && r == 0; i++) begin
         @(posedge clk);
         #1;
         if (b32.ready === 1'b1) r = i;
      end
      checks++; if (r != 31) begin fails++; $display("FAIL mid_clr_len: got %0d cycles exp 31", r); end
      model_clear();
      m_run = 1;
      b32.wr_vld = 1; b32.wr_addr = 5'd3; b32.wr_data = 32'hA5A5A5A5;
      tick();
      idle();
      b32.sb_set_vld = 1; b32.sb_set_addr = 5'd3;
      tick();
      idle();
      b32.rd_addr = {5'd3, 5'd3};
      #1;
      checks++; if (b32.rd_data !== {2{32'hA5A5A5A5}}) begin fails++; $display("FAIL run_x3: got %h exp a5a5a5a5 x2", b32.rd_data); end
      checks++; if (b32.rd_pend !== (SB ? 2'b11 : 2'b00)) begin fails++; $display("FAIL run_x3_pend: got %b exp %b", b32.rd_pend, SB ? 2'b11 : 2'b00); end
      rst_n = 0;
      m_run = 0;
      model_clear();
      #1;
      checks++; if (b32.ready !== 1'b0) begin fails++; $display("FAIL run_rst_ready: got %b exp 0", b32.ready); end
      checks++; if (b32.rd_data !== 64'd0 || b32.rd_pend !== 2'b00) begin fails++; $display("FAIL run_rst_out: got %h/%b exp 0/0", b32.rd_data, b32.rd_pend); end
      @(posedge clk);
      #1 rst_n = 1;
      r = 0;
      for (int i = 1; i <= 60 && r == 0; i++) begin
         @(posedge clk);
         #1;
         if (b32.ready === 1'b1) r = i;
      end
      checks++; if (r != 31) begin fails++; $display("FAIL run_clr_len: got %0d cycles exp 31", r); end
      m_run = 1;
      #1;
      checks++; if (b32.rd_data !== 64'd0) begin fails++; $display("FAIL x3_cleared: got %h exp 0", b32.rd_data); end
      checks++; if (b32.rd_pend !== 2'b00) begin fails++; $display("FAIL x3_pend_cleared: got %b exp 00", b32.rd_pend); end
   endtask

   task automatic test_multiport();
      idle();
      b16.wr_vld = 1; b16.wr_addr = 4'd15; b16.wr_data = 32'hCAFE;
      b16.rd_addr = {4'd0, 4'd15, 4'd15};
      #1;
      checks++; if (b16.rd_data !== {32'd0, 32'hCAFE, 32'hCAFE}) begin fails++; $display("FAIL mp_bypass: got %h exp 0/cafe/cafe", b16.rd_data); end
      @(posedge clk);
      #1;
      idle();
      #1;
      checks++; if (b16.rd_data !== {32'd0, 32'hCAFE, 32'hCAFE}) begin fails++; $display("FAIL mp_stored: got %h exp 0/cafe/cafe", b16.rd_data); end
      checks++; if (b16.rd_pend !== 3'b000) begin fails++; $display("FAIL mp_pend: got %b exp 000", b16.rd_pend); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      idle();
      b32.rd_addr = '0;
      b16.rd_addr = '0;
      model_clear();
      test_reset();
      test_bypass();
      test_x0();
      test_scoreboard();
      test_random();
      test_reset_mid();
      test_multiport();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
